// File: rtl/imem_loader.sv
// Boot loader: LE byte stream (16-bit word count, then payload) -> one imem write per 32-bit word.
// we fires the cycle after a word's 4th byte; in_ready drops for that write cycle; core held in reset until done.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam int IW = $clog2(DEPTH) + 1;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    st_idle, st_hdr0, st_hdr1, st_data, st_write, st_done, st_err
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     count_q;
  logic [1:0]      byte_cnt_q;
  logic [IW-1:0]   idx_q;
  logic [23:0]     asm_q;
  logic [15:0]     hdr_count;
  logic [IW-1:0]   idx_inc;
  logic            take;

  assign hdr_count = {in_byte, count_q[7:0]};
  assign idx_inc   = idx_q + IW'(1);
  assign take      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= st_idle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle:  if (start) state_d = st_hdr0;
      st_hdr0:  if (take) state_d = st_hdr1;
      st_hdr1: begin
        if (take) begin
          if (hdr_count == 16'd0)        state_d = st_done;
          else if (hdr_count > DEPTH_W)  state_d = st_err;
          else                           state_d = st_data;
        end
      end
      st_data:  if (take && byte_cnt_q == 2'd3) state_d = st_write;
      st_write: state_d = (16'(idx_inc) == count_q) ? st_done : st_data;
      st_done:  if (start) state_d = st_hdr0;
      st_err:   if (start) state_d = st_hdr0;
      default:  state_d = st_idle;
    endcase
  end

  // Outputs decode state only, so nothing on the input side reaches them combinationally.
  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      st_hdr0, st_hdr1, st_data: in_ready = 1'b1;
      st_write:                  we       = 1'b1;
      st_done: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      st_err:                    err      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      wa         <= '0;
      wd         <= '0;
    end else begin
      case (state_q)
        st_idle, st_done, st_err: begin
          if (start) begin
            count_q <= '0;
            asm_q   <= '0;
          end
        end
        st_hdr0: if (in_valid) count_q[7:0] <= in_byte;
        st_hdr1: begin
          if (in_valid) begin
            count_q[15:8] <= in_byte;
            byte_cnt_q    <= '0;
            idx_q         <= '0;
          end
        end
        st_data: begin
          if (in_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // The top lane goes straight into wd, so the write address/data are ready in WRITE.
            case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= in_byte;
              2'd1: asm_q[15:8]  <= in_byte;
              2'd2: asm_q[23:16] <= in_byte;
              2'd3: begin
                wa <= 32'({idx_q, 2'b00});
                wd <= {in_byte, asm_q};
              end
            endcase
          end
        end
        st_write: idx_q <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule
